branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Registered, parametrised jump/branch resolution unit with an integrated branch history table (BHT) of 2-bit saturating counters.
- Fetch side: combinational taken/not-taken prediction per PC.
- Execute side: resolves conditional branches, JAL and JALR. Computes target and link address. Flags mispredicts and misaligned targets one cycle later. Trains the BHT.
- Sits between decode/register-read and the PC redirect logic.

Parameters:
- XLEN, 32, data/address width.
- BHT_IDX_BITS, 6, log2 of BHT entries; index = pc[BHT_IDX_BITS+1:2].
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  counter[1] of the entry indexed by pred_pc (combinational).
- ex_valid  in  1  execute-stage instruction valid.
- ex_instr  in  30  instruction bits [31:2].
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_rs1_data  in  XLEN  rs1 value.
- ex_rs2_data  in  XLEN  rs2 value.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- flush  in  1  kill the execute instruction this cycle.
- res_valid  out  1  result registers valid.
- res_jack  out  1  instruction was BRANCH/JAL/JALR with a legal encoding.
- res_je  out  1  jump taken.
- res_target  out  XLEN  resolved target.
- res_link  out  XLEN  ex_pc+4.
- res_mispredict  out  1  redirect required.
- res_misaligned  out  1  taken target not 4-byte aligned.

Behaviour:
- Reset (async, rst_n=0):
  - All res_* outputs are 0.
  - All BHT counters are CTR_INIT.
  - Reset during an operation discards the in-flight result.
- Latency:
  - ex_valid=1 and flush=0 at edge N: res_* registered and res_valid=1 after edge N.
  - Otherwise res_valid=0 after the edge; other res_* hold their previous values.
- Decode, opcode = instr[6:2]:
  - BRANCH = 11000, JALR = 11001, JAL = 11011.
  - BRANCH funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU. Signed compares for BLT/BGE.
  - funct3 010/011 is illegal: jack=0, je=0, no BHT update.
- Immediates: B, J and I-type assembled per RV spec and sign-extended to XLEN.
- Targets, all arithmetic modulo 2^XLEN:
  - BRANCH: pc+immB.
  - JAL: pc+immJ.
  - JALR: (rs1+immI) with bit 0 cleared.
  - res_target is valid for not-taken branches but is ignored.
- Mispredict:
  - BRANCH: je != ex_pred_taken.
  - JAL: !ex_pred_taken.
  - JALR: always 1, because there is no target prediction.
  - Non-jump or illegal encoding: ex_pred_taken.
- Misaligned: res_misaligned = je & target[1]. When set, res_je is forced 0 and res_mispredict is forced 0; the trap path owns the redirect.
- BHT update happens on the same edge for legal BRANCH with ex_valid & !flush:
  - Actual taken: counter+1, saturating at 3.
  - Not taken: counter-1, saturating at 0.
  - JAL/JALR do not update.
- Read/write to the same index in one cycle: pred_taken shows the old value; the new value is visible the next cycle.
- Aliasing: PCs differing only above bit BHT_IDX_BITS+1 share an entry, which is accepted.

Test Plan:
1. Reset, then pred_pc=0x100 -> pred_taken=0 and all res_* are 0. Assert rst_n low mid-stream -> res_valid drops immediately.
2. BEQ, pc=0x100, immB=+16, rs1=rs2=5, ex_pred_taken=0 -> next cycle:
   - res_je=1, res_target=0x110, res_link=0x104, res_mispredict=1.
   - Counter at index 0 goes 01->10, so pred_taken(0x100)=1 one cycle later.
3. Four taken BLT (rs1=0xFFFFFFFF, rs2=1) at one PC -> counter saturates at 11. Then one BLTU with the same operands -> not taken, counter 10, pred_taken stays 1.
4. JALR, rs1=0x2001, immI=3 -> target 0x2004, je=1, mispredict=1. Then rs1=0x2003, immI=3 -> target 0x2006, res_misaligned=1, res_je=0.
5. flush=1 with ex_valid=1 on a taken BNE -> res_valid=0 next cycle, counter unchanged. funct3=010 branch -> res_jack=0, no update.
6. Aliasing: train pc=0x000 taken twice -> pred_taken(0x100)=1 with BHT_IDX_BITS=6. Same-cycle predict and update at index 0 -> pred_taken shows the pre-update value.

Source files
------------

// File: rtl/branch_unit_if.sv
// Bundle between the branch unit and its neighbours. It carries the fetch-side
// prediction lookup, the execute-side operands and the registered resolution.
// The slave modport is the branch unit. The master modport is whoever drives it.
interface branch_unit_if #(
  parameter int XLEN = 32
);

  // Fetch-side prediction lookup
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;

  // Execute-side instruction and operands
  logic            ex_valid;
  logic [29:0]     ex_instr;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic            ex_pred_taken;
  logic            flush;

  // Registered resolution results
  logic            res_valid;
  logic            res_jack;
  logic            res_je;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_mispredict;
  logic            res_misaligned;

  modport master (
    output pred_pc,
    output ex_valid, ex_instr, ex_pc, ex_rs1_data, ex_rs2_data,
    output ex_pred_taken, flush,
    input  pred_taken,
    input  res_valid, res_jack, res_je, res_target, res_link,
    input  res_mispredict, res_misaligned
  );

  modport slave (
    input  pred_pc,
    input  ex_valid, ex_instr, ex_pc, ex_rs1_data, ex_rs2_data,
    input  ex_pred_taken, flush,
    output pred_taken,
    output res_valid, res_jack, res_je, res_target, res_link,
    output res_mispredict, res_misaligned
  );

endinterface

// File: rtl/branch_unit.sv
// Jump/branch resolution unit with a built-in branch history table.
// Fetch gets a combinational taken/not-taken hint from a table of 2-bit
// saturating counters.
// Execute resolves BRANCH/JAL/JALR. It registers the target, link, mispredict
// and misaligned flags one cycle later, and trains the table on conditional
// branches.
module branch_unit #(
  parameter int         XLEN         = 32,
  parameter int         BHT_IDX_BITS = 6,
  parameter logic [1:0] CTR_INIT     = 2'b01
) (
  input logic          clk,
  input logic          rst_n,
  branch_unit_if.slave bus
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_BRANCH,
    KIND_JAL,
    KIND_JALR
  } jumpKind_e;

  // Instruction bits are indexed by their architectural position. Bits [1:0]
  // are never carried down the pipe.
  logic [31:2]     instr;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] immB;
  logic [XLEN-1:0] immJ;
  logic [XLEN-1:0] immI;

  jumpKind_e       kind;
  logic            condTaken;
  logic            jumpTaken;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            rawMispredict;
  logic            fire;

  logic [BHT_IDX_BITS-1:0] predIdx;
  logic [BHT_IDX_BITS-1:0] exIdx;
  logic [1:0]              bht_q [BHT_ENTRIES];
  logic [1:0]              exCtr;
  logic [1:0]              ctr_d;
  logic                    bhtWrite;

  logic            resValid_q,      resValid_d;
  logic            resJack_q,       resJack_d;
  logic            resJe_q,         resJe_d;
  logic [XLEN-1:0] resTarget_q,     resTarget_d;
  logic [XLEN-1:0] resLink_q,       resLink_d;
  logic            resMispredict_q, resMispredict_d;
  logic            resMisaligned_q, resMisaligned_d;

  // Only the index bits of the fetch PC select a counter. Aliasing above them
  // is accepted.
  logic unusedPredPcBits;
  assign unusedPredPcBits = ^{bus.pred_pc[XLEN-1:BHT_IDX_BITS+2], bus.pred_pc[1:0]};

  assign instr  = bus.ex_instr;
  assign opcode = instr[6:2];
  assign funct3 = instr[14:12];

  // The B, J and I immediates are scattered through the word. Each is
  // sign-extended from instr[31].
  assign immB = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immJ = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign immI = {{(XLEN-11){instr[31]}}, instr[30:20]};

  // Classify the instruction. Branches with funct3 010/011 are illegal and
  // are treated as non-jumps.
  always_comb begin
    kind = KIND_NONE;
    case (opcode)
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          kind = KIND_BRANCH;
        end
      end
      OP_JAL:  kind = KIND_JAL;
      OP_JALR: kind = KIND_JALR;
      default: kind = KIND_NONE;
    endcase
  end

  // Evaluate the branch condition. BLT/BGE compare signed, BLTU/BGEU compare
  // unsigned.
  always_comb begin
    condTaken = 1'b0;
    case (funct3)
      F3_BEQ:  condTaken = (bus.ex_rs1_data == bus.ex_rs2_data);
      F3_BNE:  condTaken = (bus.ex_rs1_data != bus.ex_rs2_data);
      F3_BLT:  condTaken = ($signed(bus.ex_rs1_data) <  $signed(bus.ex_rs2_data));
      F3_BGE:  condTaken = ($signed(bus.ex_rs1_data) >= $signed(bus.ex_rs2_data));
      F3_BLTU: condTaken = (bus.ex_rs1_data <  bus.ex_rs2_data);
      F3_BGEU: condTaken = (bus.ex_rs1_data >= bus.ex_rs2_data);
      default: condTaken = 1'b0;
    endcase
  end

  // Compute the target, whether the jump is taken, and the alignment trap.
  // JALR drops bit 0 of its sum.
  always_comb begin
    jalrSum = bus.ex_rs1_data + immI;
    case (kind)
      KIND_JALR: target = {jalrSum[XLEN-1:1], 1'b0};
      KIND_JAL:  target = bus.ex_pc + immJ;
      default:   target = bus.ex_pc + immB;
    endcase
    jumpTaken  = ((kind == KIND_BRANCH) && condTaken) ||
                 (kind == KIND_JAL) || (kind == KIND_JALR);
    misaligned = jumpTaken && target[1];
  end

  // Decide whether the front end must be redirected. JALR has no target
  // prediction, so it always redirects.
  always_comb begin
    case (kind)
      KIND_BRANCH: rawMispredict = (jumpTaken != bus.ex_pred_taken);
      KIND_JAL:    rawMispredict = !bus.ex_pred_taken;
      KIND_JALR:   rawMispredict = 1'b1;
      default:     rawMispredict = bus.ex_pred_taken;
    endcase
  end

  // Load a new result when the execute slot is live. Otherwise only drop
  // valid. A misaligned taken target hands the redirect to the trap path.
  always_comb begin
    fire            = bus.ex_valid && !bus.flush;
    resValid_d      = 1'b0;
    resJack_d       = resJack_q;
    resJe_d         = resJe_q;
    resTarget_d     = resTarget_q;
    resLink_d       = resLink_q;
    resMispredict_d = resMispredict_q;
    resMisaligned_d = resMisaligned_q;
    if (fire) begin
      resValid_d      = 1'b1;
      resJack_d       = (kind != KIND_NONE);
      resJe_d         = jumpTaken && !misaligned;
      resTarget_d     = target;
      resLink_d       = bus.ex_pc + XLEN'(4);
      resMispredict_d = rawMispredict && !misaligned;
      resMisaligned_d = misaligned;
    end
  end

  // Result registers. Reset clears them, which discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resValid_q      <= 1'b0;
      resJack_q       <= 1'b0;
      resJe_q         <= 1'b0;
      resTarget_q     <= '0;
      resLink_q       <= '0;
      resMispredict_q <= 1'b0;
      resMisaligned_q <= 1'b0;
    end else begin
      resValid_q      <= resValid_d;
      resJack_q       <= resJack_d;
      resJe_q         <= resJe_d;
      resTarget_q     <= resTarget_d;
      resLink_q       <= resLink_d;
      resMispredict_q <= resMispredict_d;
      resMisaligned_q <= resMisaligned_d;
    end
  end

  assign predIdx = bus.pred_pc[BHT_IDX_BITS+1:2];
  assign exIdx   = bus.ex_pc[BHT_IDX_BITS+1:2];
  assign exCtr   = bht_q[exIdx];

  // Compute the saturating counter step for the resolving branch. Only legal
  // conditional branches that actually retire train the table.
  always_comb begin
    bhtWrite = fire && (kind == KIND_BRANCH);
    ctr_d    = exCtr;
    if (condTaken) begin
      if (exCtr != 2'b11) begin
        ctr_d = exCtr + 2'd1;
      end
    end else begin
      if (exCtr != 2'b00) begin
        ctr_d = exCtr - 2'd1;
      end
    end
  end

  // Counter table. A same-cycle read sees the old value until the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else if (bhtWrite) begin
      bht_q[exIdx] <= ctr_d;
    end
  end

  assign bus.pred_taken     = bht_q[predIdx][1];
  assign bus.res_valid      = resValid_q;
  assign bus.res_jack       = resJack_q;
  assign bus.res_je         = resJe_q;
  assign bus.res_target     = resTarget_q;
  assign bus.res_link       = resLink_q;
  assign bus.res_mispredict = resMispredict_q;
  assign bus.res_misaligned = resMisaligned_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit.
// Directed scenarios are followed by randomized traffic. Every result is
// compared against a behavioural model of the counter table and of the
// resolution rules.
module tb_branch_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  branch_unit_if #(.XLEN(32)) bus();

  branch_unit #(
    .XLEN(32),
    .BHT_IDX_BITS(6),
    .CTR_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state: a counter value 0..3 per entry, plus the
  // expected registered results.
  int          bhtM [64];
  logic        eValid, eJack, eJe, eMisp, eMisal, eTargetKnown;
  logic [31:0] eTarget, eLink;

  // Instruction kinds, as chosen by the stimulus generator.
  localparam int K_BRANCH = 0;
  localparam int K_JAL    = 1;
  localparam int K_JALR   = 2;
  localparam int K_OTHER  = 3;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) bhtM[i] = 1;
    eValid = 0; eJack = 0; eJe = 0; eMisp = 0; eMisal = 0;
    eTarget = 0; eLink = 0; eTargetKnown = 1;
  endfunction

  function automatic int idxOf(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic [31:0] modelPred(input logic [31:0] pc);
    return (bhtM[idxOf(pc)] >= 2) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [29:0] encB(input logic [2:0] f3, input logic [12:0] im);
    return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 5'b11000};
  endfunction

  function automatic logic [29:0] encJ(input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], 5'd1, 5'b11011};
  endfunction

  function automatic logic [29:0] encI(input logic [11:0] im);
    return {im[11:0], 5'd1, 3'b000, 5'd1, 5'b11001};
  endfunction

  task automatic checkResults();
    checkOutput("res_valid", 32'(bus.res_valid), 32'(eValid));
    checkOutput("res_jack", 32'(bus.res_jack), 32'(eJack));
    checkOutput("res_je", 32'(bus.res_je), 32'(eJe));
    checkOutput("res_link", bus.res_link, eLink);
    checkOutput("res_mispredict", 32'(bus.res_mispredict), 32'(eMisp));
    checkOutput("res_misaligned", 32'(bus.res_misaligned), 32'(eMisal));
    if (eTargetKnown) checkOutput("res_target", bus.res_target, eTarget);
  endtask

  // Drive one execute-stage instruction plus a fetch lookup. Check the
  // prediction before the edge. Advance the model. Check everything after the
  // edge.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                               input logic pred, input logic v, input logic fl,
                               input logic [31:0] ppc, input logic [29:0] raw);
    logic        legalBr, taken, je, mis;
    logic [31:0] tgt;
    @(negedge clk);
    case (kind)
      K_BRANCH: bus.ex_instr = encB(f3, imm[12:0]);
      K_JAL:    bus.ex_instr = encJ(imm[20:0]);
      K_JALR:   bus.ex_instr = encI(imm[11:0]);
      default:  bus.ex_instr = raw;
    endcase
    bus.ex_pc = pc; bus.ex_rs1_data = a; bus.ex_rs2_data = b;
    bus.ex_pred_taken = pred; bus.ex_valid = v; bus.flush = fl; bus.pred_pc = ppc;
    #1;
    checkOutput("pred_taken_pre", 32'(bus.pred_taken), modelPred(ppc));

    if (v && !fl) begin
      legalBr = (kind == K_BRANCH) && (f3 != 3'd2) && (f3 != 3'd3);
      case (f3)
        3'd0:    taken = (a == b);
        3'd1:    taken = (a != b);
        3'd4:    taken = ($signed(a) < $signed(b));
        3'd5:    taken = ($signed(a) >= $signed(b));
        3'd6:    taken = (a < b);
        3'd7:    taken = (a >= b);
        default: taken = 0;
      endcase
      je  = legalBr ? taken : (kind == K_JAL || kind == K_JALR);
      tgt = (kind == K_JALR) ? ((a + imm) & ~32'h1) : (pc + imm);
      mis = je && tgt[1];
      eValid = 1;
      eJack = legalBr || kind == K_JAL || kind == K_JALR;
      eJe = je && !mis;
      eTarget = tgt;
      eTargetKnown = eJack;
      eLink = pc + 32'd4;
      if (legalBr) eMisp = (je != pred);
      else if (kind == K_JAL) eMisp = !pred;
      else if (kind == K_JALR) eMisp = 1;
      else eMisp = pred;
      if (mis) eMisp = 0;
      eMisal = mis;
      if (legalBr) begin
        if (taken) bhtM[idxOf(pc)] = (bhtM[idxOf(pc)] == 3) ? 3 : bhtM[idxOf(pc)] + 1;
        else       bhtM[idxOf(pc)] = (bhtM[idxOf(pc)] == 0) ? 0 : bhtM[idxOf(pc)] - 1;
      end
    end else begin
      eValid = 0;
    end

    @(posedge clk);
    #1;
    checkResults();
    checkOutput("pred_taken_post", 32'(bus.pred_taken), modelPred(ppc));
  endtask

  // Assert reset between clock edges. The results must clear at once,
  // without waiting for a clock.
  task automatic applyReset();
    #2;
    rst_n = 0;
    bus.ex_valid = 0;
    #1;
    modelReset();
    checkResults();
    checkOutput("pred_taken_rst", 32'(bus.pred_taken), modelPred(bus.pred_pc));
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] pc, a, b, imm, ppc;
    logic [29:0] raw;
    logic [12:0] s13;
    logic [20:0] s21;
    logic [11:0] s12;
    int          kr, kind;

    rst_n = 0;
    bus.pred_pc = 32'h100; bus.ex_valid = 0; bus.ex_instr = '0; bus.ex_pc = '0;
    bus.ex_rs1_data = '0; bus.ex_rs2_data = '0; bus.ex_pred_taken = 0; bus.flush = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResults();
    checkOutput("reset_pred", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Taken BEQ from a predicted-not-taken slot. Index 0 trains to weakly taken.
    applyStimulus(K_BRANCH, 3'b000, 32'd16, 32'h100, 32'd5, 32'd5, 0, 1, 0, 32'h100, '0);
    checkOutput("beq_target", bus.res_target, 32'h110);
    checkOutput("beq_link", bus.res_link, 32'h104);
    checkOutput("beq_misp", 32'(bus.res_mispredict), 32'd1);
    checkOutput("beq_pred_after", 32'(bus.pred_taken), 32'd1);
    applyReset();

    // Signed BLT saturates the counter. The unsigned BLTU with the same
    // operands is not taken.
    for (int i = 0; i < 4; i++)
      applyStimulus(K_BRANCH, 3'b100, 32'd8, 32'h204, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 32'h204, '0);
    applyStimulus(K_BRANCH, 3'b110, 32'd8, 32'h204, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 32'h204, '0);
    checkOutput("bltu_je", 32'(bus.res_je), 32'd0);
    checkOutput("bltu_pred", 32'(bus.pred_taken), 32'd1);

    // JALR: bit 0 of the sum is dropped. A sum with bit 1 set traps as
    // misaligned.
    applyStimulus(K_JALR, 3'b000, 32'd3, 32'h300, 32'h2001, 32'd0, 0, 1, 0, 32'h300, '0);
    checkOutput("jalr_target", bus.res_target, 32'h2004);
    checkOutput("jalr_misp", 32'(bus.res_mispredict), 32'd1);
    applyStimulus(K_JALR, 3'b000, 32'd3, 32'h300, 32'h2003, 32'd0, 0, 1, 0, 32'h300, '0);
    checkOutput("jalr_mis_target", bus.res_target, 32'h2006);
    checkOutput("jalr_misaligned", 32'(bus.res_misaligned), 32'd1);
    checkOutput("jalr_mis_je", 32'(bus.res_je), 32'd0);

    // A flushed BNE does not retire and does not train. The illegal funct3
    // 010 is not a jump.
    applyStimulus(K_BRANCH, 3'b001, 32'd8, 32'h208, 32'd1, 32'd2, 0, 1, 1, 32'h208, '0);
    checkOutput("flush_valid", 32'(bus.res_valid), 32'd0);
    applyStimulus(K_BRANCH, 3'b010, 32'd8, 32'h208, 32'd1, 32'd1, 0, 1, 0, 32'h208, '0);
    checkOutput("illegal_jack", 32'(bus.res_jack), 32'd0);
    checkOutput("illegal_pred", 32'(bus.pred_taken), 32'd0);

    // Aliasing: training PC 0 moves the entry that PC 0x100 reads. Then
    // predict and update the same index in one cycle.
    applyReset();
    applyStimulus(K_BRANCH, 3'b000, 32'd8, 32'h000, 32'd7, 32'd7, 0, 1, 0, 32'h100, '0);
    applyStimulus(K_BRANCH, 3'b000, 32'd8, 32'h000, 32'd7, 32'd7, 1, 1, 0, 32'h100, '0);
    checkOutput("alias_pred", 32'(bus.pred_taken), 32'd1);
    applyStimulus(K_BRANCH, 3'b000, 32'd8, 32'h000, 32'd7, 32'd8, 1, 1, 0, 32'h100, '0);
    applyStimulus(K_BRANCH, 3'b000, 32'd8, 32'h000, 32'd7, 32'd8, 1, 1, 0, 32'h100, '0);
    checkOutput("same_cycle_post", 32'(bus.pred_taken), 32'd0);

    // Randomized traffic. The PCs are confined to a few entries so that the
    // counters get exercised.
    for (int n = 0; n < 600; n++) begin
      kr = $urandom_range(0, 9);
      kind = (kr <= 4) ? K_BRANCH : (kr <= 6) ? K_JAL : (kr == 7) ? K_JALR : K_OTHER;
      pc  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      ppc = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      s13 = 13'($urandom) & 13'h1FFE;
      s21 = 21'($urandom) & 21'h1FFFFE;
      s12 = 12'($urandom);
      case (kind)
        K_BRANCH: imm = {{19{s13[12]}}, s13};
        K_JAL:    imm = {{11{s21[20]}}, s21};
        K_JALR:   imm = {{20{s12[11]}}, s12};
        default:  imm = 32'd0;
      endcase
      raw = 30'($urandom);
      if (raw[4:0] == 5'b11000 || raw[4:0] == 5'b11001 || raw[4:0] == 5'b11011) raw[4:0] = 5'b00100;
      applyStimulus(kind, 3'($urandom_range(0, 7)), imm, pc, a, b, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), ppc, raw);
      if (n % 150 == 149) applyReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
